// File: rtl/audio_pkg.sv
// Shared audio types and widths for the tone path (note generator and I2S sink).
package audio_pkg;

    localparam int unsigned AUDIO_W    = 16;
    localparam int unsigned FRAME_BITS = 32;

    typedef logic signed [AUDIO_W-1:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t left;
        audio_sample_t right;
    } stereo_frame_t;

endpackage

// File: rtl/i2s_clk_div.sv
// Free-running divider producing MCLK/SCK/LRCK as register taps plus shift/frame edge decodes.
module i2s_clk_div
    import audio_pkg::*;
#(
    parameter int unsigned MCLK_DIV_LOG2 = 2,
    parameter int unsigned SCK_DIV_LOG2  = 4
) (
    input  logic clk,
    input  logic rst,
    output logic mclk,
    output logic sck,
    output logic lrck,
    output logic shift_edge_c,
    output logic frame_edge_c
);

    localparam int unsigned CW = SCK_DIV_LOG2 + $clog2(FRAME_BITS);

    if (MCLK_DIV_LOG2 < 1 || SCK_DIV_LOG2 <= MCLK_DIV_LOG2) begin : g_bad_params
        $error("i2s_clk_div: need 1 <= MCLK_DIV_LOG2 < SCK_DIV_LOG2");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Clock outputs are straight register bits, so they cannot glitch.
    assign mclk = cnt[MCLK_DIV_LOG2-1];
    assign sck  = cnt[SCK_DIV_LOG2-1];
    assign lrck = cnt[CW-1];

    assign shift_edge_c = &cnt[SCK_DIV_LOG2-1:0];
    assign frame_edge_c = &cnt;

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter for the Pmod I2S DAC; captures one stereo sample per frame.
// Optional mute input enabled by defining I2S_TX_MUTE_EN.
module i2s_audio_tx
    import audio_pkg::*;
#(
    parameter int unsigned MCLK_DIV_LOG2 = 2,
    parameter int unsigned SCK_DIV_LOG2  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  audio_sample_t audio_left,
    input  audio_sample_t audio_right,
`ifdef I2S_TX_MUTE_EN
    input  logic          mute,
`endif
    output logic          sample_strobe,
    output logic          audio_mclk,
    output logic          audio_lrck,
    output logic          audio_sck,
    output logic          audio_sdin
);

    logic                  shift_edge_c;
    logic                  frame_edge_c;
    logic [FRAME_BITS-1:0] shreg;
    stereo_frame_t         load_c;

    i2s_clk_div #(
        .MCLK_DIV_LOG2 (MCLK_DIV_LOG2),
        .SCK_DIV_LOG2  (SCK_DIV_LOG2)
    ) u_clk_div (
        .clk          (clk),
        .rst          (rst),
        .mclk         (audio_mclk),
        .sck          (audio_sck),
        .lrck         (audio_lrck),
        .shift_edge_c (shift_edge_c),
        .frame_edge_c (frame_edge_c)
    );

    assign sample_strobe = frame_edge_c;

    // Word loaded at the frame edge; muting only ever replaces a whole frame.
    always_comb begin
        load_c.left  = audio_left;
        load_c.right = audio_right;
`ifdef I2S_TX_MUTE_EN
        if (mute) begin
            load_c = '0;
        end
`endif
    end

    // SDIN takes the outgoing MSB on every SCK falling edge, giving the 1-SCK I2S delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            audio_sdin <= 1'b0;
        end else if (shift_edge_c) begin
            audio_sdin <= shreg[FRAME_BITS-1];
            if (frame_edge_c) begin
                shreg <= load_c;
            end else begin
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: clock-tap checks plus an I2S decode scoreboard.
module tb_i2s_audio_tx;
    import audio_pkg::*;

    localparam int unsigned FRAME_CLK = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    audio_sample_t l_in = '0;
    audio_sample_t r_in = '0;
    logic          mute_v = 1'b0;
    logic          sample_strobe;
    logic          audio_mclk;
    logic          audio_lrck;
    logic          audio_sck;
    logic          audio_sdin;

    int n_total = 0;
    int n_bad   = 0;
    int n_words = 0;

    i2s_audio_tx dut (
        .clk           (clk),
        .rst           (rst),
        .audio_left    (l_in),
        .audio_right   (r_in),
`ifdef I2S_TX_MUTE_EN
        .mute          (mute_v),
`endif
        .sample_strobe (sample_strobe),
        .audio_mclk    (audio_mclk),
        .audio_lrck    (audio_lrck),
        .audio_sck     (audio_sck),
        .audio_sdin    (audio_sdin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference cycle count since reset release.
    int unsigned tcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) tcnt <= 0;
        else     tcnt <= tcnt + 1;
    end

    logic [31:0] sb_q[$];
    logic        sck_q  = 1'b0;
    logic        lrck_q = 1'b0;
    logic [15:0] acc    = '0;

    always @(negedge clk) begin
        int unsigned c;
        logic [31:0] exp_word;
        c = tcnt % FRAME_CLK;
        check("mclk",   32'(audio_mclk),    32'((c >> 1) & 1));
        check("sck",    32'(audio_sck),     32'((c >> 3) & 1));
        check("lrck",   32'(audio_lrck),    32'((c >> 8) & 1));
        check("strobe", 32'(sample_strobe), 32'(c == FRAME_CLK - 1));
        if (rst) begin
            check("sdin_rst", 32'(audio_sdin), 32'(0));
            sb_q.delete();
            sb_q.push_back(32'h0);
            sck_q  = 1'b0;
            lrck_q = 1'b0;
            acc    = '0;
        end else begin
            if (sample_strobe) begin
                exp_word = {l_in, r_in};
`ifdef I2S_TX_MUTE_EN
                if (mute_v) exp_word = 32'h0;
`endif
                sb_q.push_back(exp_word);
            end
            if (audio_sck && !sck_q) begin
                acc = {acc[14:0], audio_sdin};
                if (audio_lrck && !lrck_q) begin
                    if (sb_q.size() == 0) check("sb_empty_left", 32'(0), 32'(1));
                    else check("left_word", 32'(acc), 32'(sb_q[0][31:16]));
                    n_words++;
                end else if (!audio_lrck && lrck_q) begin
                    if (sb_q.size() == 0) check("sb_empty_right", 32'(0), 32'(1));
                    else begin
                        check("right_word", 32'(acc), 32'(sb_q[0][15:0]));
                        void'(sb_q.pop_front());
                    end
                    n_words++;
                end
                lrck_q = audio_lrck;
            end
            sck_q = audio_sck;
        end
    end

    // Returns just after the capturing clock edge, so new inputs cannot affect that frame.
    task automatic wait_strobe();
        bit seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (sample_strobe) seen = 1'b1;
        end
        if (!seen) check("strobe_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] corner [4] = '{32'h8000_7FFF, 32'h7FFF_8000, 32'h0001_FFFE, 32'hFFFF_0000};

    initial begin
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;

        l_in = 16'hA5C3;
        r_in = 16'h3C5A;
        repeat (3) wait_strobe();

        // Mid-frame input change must not leak into the frame in flight.
        l_in = 16'h1234;
        wait_strobe();
        repeat (8 * 16) @(posedge clk);
        #1 l_in = 16'hFFFF;
        wait_strobe();

        for (int i = 0; i < 4; i++) begin
            {l_in, r_in} = corner[i];
            wait_strobe();
        end

        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1, 400)) @(posedge clk);
            #1;
            l_in = 16'($urandom);
            r_in = 16'($urandom);
            wait_strobe();
        end

        // Reset pulse in slot 20.
        wait_strobe();
        repeat (20 * 16) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        l_in = 16'h5A5A;
        r_in = 16'hC33C;
        repeat (2) wait_strobe();

`ifdef I2S_TX_MUTE_EN
        l_in = 16'h7FFF;
        r_in = 16'h7FFF;
        wait_strobe();
        mute_v = 1'b1;
        wait_strobe();
        mute_v = 1'b0;
        repeat (2) wait_strobe();
`endif

        repeat (2) wait_strobe();
        check("word_count", 32'(n_words >= 30), 32'(1));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
